mag_countdown_timer: RTL and testbench

//  Cook-time countdown for the microwave magnetron controller. Captures MM:SS from keypad

---
 rtl/mag_countdown_timer_pkg.sv | 20 ++
 rtl/mag_bcd_down_digit.sv | 22 ++
 rtl/mag_countdown_timer.sv | 141 ++++++++++++++
 tb/tb_mag_countdown_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_countdown_timer_pkg.sv
// Shared encodings and constants for the magnetron cook-time countdown.
package mag_countdown_timer_pkg;

  typedef enum logic [2:0] {
    MAG_ST_IDLE  = 3'd0,
    MAG_ST_ENTRY = 3'd1,
    MAG_ST_RUN   = 3'd2,
    MAG_ST_PAUSE = 3'd3,
    MAG_ST_DONE  = 3'd4
  } mag_state_e;

  localparam logic [15:0] BCD_ZERO     = 16'h0000;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  DIGIT_MAX    = 4'd9;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/mag_bcd_down_digit.sv
// One BCD digit of the down-counter: decrements, wrapping 0 to MAX with a borrow.
module mag_bcd_down_digit
  import mag_countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic [3:0] value,
  input  logic       dec_in,
  output logic [3:0] value_nxt,
  output logic       borrow_out
);

  assign borrow_out = dec_in && (value == 4'd0);

  always_comb begin
    value_nxt = value;
    if (dec_in) begin
      value_nxt = (value == 4'd0) ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/mag_countdown_timer.sv
// MM:SS cook-time countdown: keypad entry shifter, run/pause/done FSM, 1 Hz decrement.
// Optional end-of-cook beep output is built when MAG_TIMER_BEEP_EN is defined.
module mag_countdown_timer
  import mag_countdown_timer_pkg::*;
#(
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick_1hz,
  input  logic        digit_valid,
  input  logic [3:0]  digit_in,
  input  logic        clearn,
  input  logic        mag_on,
  output logic [15:0] time_bcd,
  output logic        running,
`ifdef MAG_TIMER_BEEP_EN
  output logic        beep,
`endif
  output logic        timer_done
);

  mag_state_e  state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        running_q;
  logic        done_q;

  logic [3:0]  su_n, st_n, mu_n, mt_n;
  logic        b_su, b_st, b_mu, b_mt;
  logic [15:0] dec_val;
  logic        digit_take;

  // Borrow chain; seconds tens wraps to 5 so 1:00 becomes 0:59.
  mag_bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_u (
    .value(time_q[3:0]), .dec_in(1'b1), .value_nxt(su_n), .borrow_out(b_su));
  mag_bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_t (
    .value(time_q[7:4]), .dec_in(b_su), .value_nxt(st_n), .borrow_out(b_st));
  mag_bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_u (
    .value(time_q[11:8]), .dec_in(b_st), .value_nxt(mu_n), .borrow_out(b_mu));
  mag_bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_t (
    .value(time_q[15:12]), .dec_in(b_mu), .value_nxt(mt_n), .borrow_out(b_mt));

  assign dec_val = {mt_n, mu_n, st_n, su_n};

  assign digit_take = digit_valid && digit_ok(digit_in) &&
                      (state_q inside {MAG_ST_IDLE, MAG_ST_ENTRY, MAG_ST_DONE});

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (!clearn) begin
      state_d = MAG_ST_IDLE;
      time_d  = BCD_ZERO;
    end else if (digit_take) begin
      time_d  = (state_q == MAG_ST_DONE) ? {12'h000, digit_in} : {time_q[11:0], digit_in};
      state_d = MAG_ST_ENTRY;
    end else begin
      case (state_q)
        MAG_ST_IDLE: begin
          if (mag_on) state_d = MAG_ST_DONE;
        end
        MAG_ST_ENTRY: begin
          // A zero cook time must never energise the magnetron; go straight to DONE.
          if (mag_on) state_d = (time_q == BCD_ZERO) ? MAG_ST_DONE : MAG_ST_RUN;
        end
        MAG_ST_RUN: begin
          if (!mag_on) begin
            state_d = MAG_ST_PAUSE;
          end else if (tick_1hz && !b_mt) begin
            time_d = dec_val;
            if (dec_val == BCD_ZERO) state_d = MAG_ST_DONE;
          end
        end
        MAG_ST_PAUSE: begin
          if (mag_on) state_d = MAG_ST_RUN;
        end
        MAG_ST_DONE: begin
          time_d = BCD_ZERO;
        end
        default: begin
          state_d = MAG_ST_IDLE;
          time_d  = BCD_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MAG_ST_IDLE;
      time_q    <= BCD_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= (state_d == MAG_ST_RUN);
      done_q    <= (state_d == MAG_ST_DONE);
    end
  end

  assign time_bcd   = time_q;
  assign running    = running_q;
  assign timer_done = done_q;

`ifdef MAG_TIMER_BEEP_EN
  localparam logic [7:0] BEEP_LAST = 8'(BEEP_TICKS - 1);

  logic       beep_q, beep_d;
  logic [7:0] beep_cnt_q, beep_cnt_d;

  // Any fresh entry into DONE restarts the alert; leaving DONE silences it.
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (state_d == MAG_ST_DONE && state_q != MAG_ST_DONE) begin
      beep_d     = 1'b1;
      beep_cnt_d = 8'd0;
    end else if (state_d != MAG_ST_DONE) begin
      beep_d     = 1'b0;
      beep_cnt_d = 8'd0;
    end else if (beep_q && tick_1hz) begin
      beep_cnt_d = beep_cnt_q + 8'd1;
      if (beep_cnt_q == BEEP_LAST) beep_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= 8'd0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_mag_countdown_timer.sv
// Self-checking bench for mag_countdown_timer: directed cook scenarios plus random traffic.
module tb_mag_countdown_timer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick_1hz;
  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        clearn;
  logic        mag_on;
  logic [15:0] time_bcd;
  logic        running;
  logic        timer_done;
`ifdef MAG_TIMER_BEEP_EN
  logic        beep;
`endif

  mag_countdown_timer dut (
    .clk(clk), .resetn(resetn), .tick_1hz(tick_1hz), .digit_valid(digit_valid),
    .digit_in(digit_in), .clearn(clearn), .mag_on(mag_on), .time_bcd(time_bcd),
    .running(running),
`ifdef MAG_TIMER_BEEP_EN
    .beep(beep),
`endif
    .timer_done(timer_done));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: modes as small integers, time as minutes and seconds.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int m_mode;
  int m_dg[4];      // m_dg[3] = minute tens ... m_dg[0] = second units
  bit m_beep;
  int m_ticks;

  function automatic logic [15:0] m_bcd();
    return {4'(m_dg[3]), 4'(m_dg[2]), 4'(m_dg[1]), 4'(m_dg[0])};
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    for (int i = 0; i < 4; i++) m_dg[i] = 0;
    m_beep = 0;
    m_ticks = 0;
  endtask

  task automatic m_step(input bit dv, input int d, input bit mo, input bit tk, input bit cl);
    int prev, mins, secs;
    prev = m_mode;
    if (!cl) begin
      m_mode = M_IDLE;
      for (int i = 0; i < 4; i++) m_dg[i] = 0;
    end else if (dv && d <= 9 && (m_mode == M_IDLE || m_mode == M_ENTRY || m_mode == M_DONE)) begin
      if (m_mode == M_DONE) begin
        m_dg[3] = 0; m_dg[2] = 0; m_dg[1] = 0;
      end else begin
        m_dg[3] = m_dg[2]; m_dg[2] = m_dg[1]; m_dg[1] = m_dg[0];
      end
      m_dg[0] = d;
      m_mode = M_ENTRY;
    end else if (m_mode == M_IDLE && mo) begin
      m_mode = M_DONE;
    end else if (m_mode == M_ENTRY && mo) begin
      m_mode = (m_bcd() == 16'h0000) ? M_DONE : M_RUN;
    end else if (m_mode == M_RUN && !mo) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_RUN && tk) begin
      mins = m_dg[3] * 10 + m_dg[2];
      secs = m_dg[1] * 10 + m_dg[0];
      if (secs > 0) secs--;
      else begin mins--; secs = 59; end
      m_dg[3] = mins / 10; m_dg[2] = mins % 10;
      m_dg[1] = secs / 10; m_dg[0] = secs % 10;
      if (mins == 0 && secs == 0) m_mode = M_DONE;
    end else if (m_mode == M_PAUSE && mo) begin
      m_mode = M_RUN;
    end
    if (m_mode == M_DONE && prev != M_DONE) begin
      m_beep = 1; m_ticks = 0;
    end else if (m_mode != M_DONE) begin
      m_beep = 0;
    end else if (m_beep && tk) begin
      m_ticks++;
      if (m_ticks == 3) m_beep = 0;
    end
  endtask

  task automatic cmp_model();
    chk("time", time_bcd, m_bcd());
    chk("running", 16'(running), 16'(m_mode == M_RUN));
    chk("done", 16'(timer_done), 16'(m_mode == M_DONE));
`ifdef MAG_TIMER_BEEP_EN
    chk("beep", 16'(beep), 16'(m_beep));
`endif
  endtask

  task automatic cyc(input bit dv, input int d, input bit mo, input bit tk, input bit cl);
    digit_valid = dv;
    digit_in    = 4'(d);
    mag_on      = mo;
    tick_1hz    = tk;
    clearn      = cl;
    @(posedge clk);
    m_step(dv, d, mo, tk, cl);
    #1;
    cmp_model();
  endtask

  task automatic enter(input int d);
    cyc(1, d, 0, 0, 1);
  endtask

  task automatic clear();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit mo;
    resetn = 1'b0; tick_1hz = 0; digit_valid = 0; digit_in = 0; clearn = 1; mag_on = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_done", 16'(timer_done), 16'h0);
    @(negedge clk);
    resetn = 1'b1;

    // 1:30 running for five seconds
    enter(1); enter(3); enter(0);
    chk("entry_130", time_bcd, 16'h0130);
    cyc(0, 0, 1, 0, 1);
    repeat (5) cyc(0, 0, 1, 1, 1);
    chk("run_0125", time_bcd, 16'h0125);
    chk("run_running", 16'(running), 16'h1);
    clear();

    // 0:01 expires on one tick
    enter(1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("exp_time", time_bcd, 16'h0000);
    chk("exp_done", 16'(timer_done), 16'h1);
    chk("exp_running", 16'(running), 16'h0);
    clear();

    // minute and ten-minute borrows
    enter(1); enter(0); enter(0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("borrow_0059", time_bcd, 16'h0059);
    clear();
    enter(1); enter(0); enter(0); enter(0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("borrow_0959", time_bcd, 16'h0959);
    clear();

    // pause and resume; tick on resume edge is ignored
    enter(3); enter(0);
    cyc(0, 0, 1, 0, 1);
    repeat (3) cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("pause_time", time_bcd, 16'h0027);
    chk("pause_running", 16'(running), 16'h0);
    repeat (4) cyc(0, 0, 0, 1, 1);
    chk("pause_hold", time_bcd, 16'h0027);
    cyc(0, 0, 1, 1, 1);
    chk("resume_time", time_bcd, 16'h0027);
    chk("resume_running", 16'(running), 16'h1);
    cyc(0, 0, 1, 1, 1);
    chk("resume_tick", time_bcd, 16'h0026);
    clear();

    // five digits, invalid digit, clear mid-run
    enter(1); enter(2); enter(3); enter(4); enter(5);
    chk("shift_2345", time_bcd, 16'h2345);
    enter(10);
    chk("digit_A_ign", time_bcd, 16'h2345);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("run_2344", time_bcd, 16'h2344);
    cyc(0, 0, 1, 0, 0);
    chk("clr_time", time_bcd, 16'h0000);
    chk("clr_running", 16'(running), 16'h0);
    clear();

    // start with zero time
    cyc(0, 0, 1, 0, 1);
    chk("zero_done", 16'(timer_done), 16'h1);
`ifdef MAG_TIMER_BEEP_EN
    chk("beep_on", 16'(beep), 16'h1);
    repeat (2) cyc(0, 0, 1, 1, 1);
    chk("beep_hold", 16'(beep), 16'h1);
    cyc(0, 0, 1, 1, 1);
    chk("beep_off", 16'(beep), 16'h0);
`endif
    cyc(1, 7, 0, 0, 1);
    chk("done_digit", time_bcd, 16'h0007);
    clear();

    // literal seconds above 59
    enter(7); enter(5);
    cyc(0, 0, 1, 0, 1);
    repeat (6) cyc(0, 0, 1, 1, 1);
    chk("lit_0069", time_bcd, 16'h0069);

    // asynchronous reset while running
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    m_reset();
    chk("arst_time", time_bcd, 16'h0000);
    chk("arst_running", 16'(running), 16'h0);
    chk("arst_done", 16'(timer_done), 16'h0);
    mag_on = 0; tick_1hz = 0; digit_valid = 0; clearn = 1;
    @(negedge clk);
    resetn = 1'b1;

    // random traffic against the model
    mo = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) mo = ~mo;
      cyc(($urandom_range(5) == 0), int'($urandom_range(15)), mo,
          ($urandom_range(2) == 0), ($urandom_range(59) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
